// File: rtl/video_timing_gen_param.sv
// video_timing_gen_param: pixel clock enables, H/V raster counters and the
// registered blanking/sync/flip/DMA decodes for the top of the video pipeline.
// The vertical total is selectable at runtime. The selection and the flip
// controls are latched on frame-synchronous edges, so a change never tears
// the frame that is currently being drawn.
module video_timing_gen_param #(
    parameter int CEN_DIV      = 8,
    parameter int HW           = 9,
    parameter int VW           = 9,
    parameter int H_TOTAL      = 384,
    parameter int H_ACT_END    = 256,
    parameter int H_SYNC_START = 288,
    parameter int H_SYNC_END   = 320,
    parameter int V_TOTAL_0    = 264,
    parameter int V_TOTAL_1    = 262,
    parameter int V_ACT_START  = 16,
    parameter int V_ACT_END    = 240,
    parameter int V_SYNC_START = 248,
    parameter int V_SYNC_END   = 256,
    parameter int DMA_LINES    = 4
) (
    input  logic          i_MCLK,
    input  logic          i_MRST_n,
    input  logic          i_HFLIP,
    input  logic          i_VFLIP,
    input  logic          i_VMODE,
    output logic          o_PXPOSCEN_n,
    output logic          o_PXNEGCEN_n,
    output logic [HW-1:0] o_HCNTR,
    output logic [VW-1:0] o_VCNTR,
    output logic [HW-1:0] o_HFLIPCNTR,
    output logic [VW-1:0] o_VFLIPCNTR,
    output logic          o_HBLANK_n,
    output logic          o_VBLANK_n,
    output logic          o_BLANK_n,
    output logic          o_HSYNC_n,
    output logic          o_VSYNC_n,
    output logic          o_CSYNC_n,
    output logic          o_VCLK,
    output logic          o_FRAMEPARITY,
    output logic          o_DMA_n
);

    localparam int DW          = $clog2(CEN_DIV);
    localparam int V_TOTAL_MIN = (V_TOTAL_0 < V_TOTAL_1) ? V_TOTAL_0 : V_TOTAL_1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CEN_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CEN_DIV / 2 - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [VW-1:0] V_ONE    = VW'(1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACT_END);
    localparam logic [HW-1:0] H_HALF   = HW'(H_TOTAL / 2);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_SYNC_START);
    localparam logic [HW-1:0] HS_END   = HW'(H_SYNC_END);
    localparam logic [VW-1:0] V_LAST0  = VW'(V_TOTAL_0 - 1);
    localparam logic [VW-1:0] V_LAST1  = VW'(V_TOTAL_1 - 1);
    localparam logic [VW-1:0] VA_BEG   = VW'(V_ACT_START);
    localparam logic [VW-1:0] VA_END   = VW'(V_ACT_END);
    localparam logic [VW-1:0] VF_LINE  = VW'(V_ACT_END - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_SYNC_START);
    localparam logic [VW-1:0] VS_END   = VW'(V_SYNC_END);
    localparam logic [VW-1:0] DMA_END  = VW'(V_ACT_END + DMA_LINES);

    // Raster geometry must fit inside the shorter of the two frame totals.
    if ((CEN_DIV < 2) || ((CEN_DIV % 2) != 0)) begin : g_chk_div
        $error("CEN_DIV must be even and at least 2");
    end
    if (H_SYNC_END > H_TOTAL) begin : g_chk_hsync
        $error("H_SYNC_END exceeds H_TOTAL");
    end
    if (V_SYNC_END > V_TOTAL_MIN) begin : g_chk_vsync
        $error("V_SYNC_END exceeds the shorter vertical total");
    end
    if ((V_ACT_END + DMA_LINES) > V_TOTAL_MIN) begin : g_chk_dma
        $error("DMA window exceeds the shorter vertical total");
    end

    logic [DW-1:0] div_q, div_d;
    logic          pxpos_q, pxpos_d, pxneg_q, pxneg_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          vmode_q, vmode_d, parity_q, parity_d;
    logic          hflip_q, hflip_d, vflip_q, vflip_d;
    logic          hblank_q, hblank_d, vblank_q, vblank_d, blank_q, blank_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, csync_q, csync_d;
    logic          vclk_q, vclk_d, dma_q, dma_d;
    logic [HW-1:0] hflipcnt_q, hflipcnt_d;
    logic [VW-1:0] vflipcnt_q, vflipcnt_d;
    logic [VW-1:0] v_last_s;

    // Divider, raster advance, frame-synchronous latches and look-ahead decodes.
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? {DW{1'b0}} : (div_q + DIV_ONE);
        pxpos_d  = (div_q != DIV_LAST);
        pxneg_d  = (div_q != DIV_HALF);
        h_d      = h_q;
        v_d      = v_q;
        vmode_d  = vmode_q;
        parity_d = parity_q;
        hflip_d  = hflip_q;
        vflip_d  = vflip_q;
        v_last_s = vmode_q ? V_LAST1 : V_LAST0;

        // The edge that ends a PXPOSCEN_n-low cycle moves the raster by one pixel.
        if (!pxpos_q) begin
            if (h_q == H_LAST) begin
                h_d = {HW{1'b0}};
                if (v_q == v_last_s) begin
                    v_d      = {VW{1'b0}};
                    vmode_d  = i_VMODE;
                    parity_d = ~parity_q;
                end else begin
                    v_d = v_q + V_ONE;
                end
                // Entering the first blanked line: flips only change in vblank.
                if (v_q == VF_LINE) begin
                    hflip_d = i_HFLIP;
                    vflip_d = i_VFLIP;
                end else begin
                    hflip_d = hflip_q;
                    vflip_d = vflip_q;
                end
            end else begin
                h_d = h_q + H_ONE;
            end
        end else begin
            h_d = h_q;
            v_d = v_q;
        end

        // Decodes look at the next counter values so they switch with the counters.
        hblank_d   = (h_d < H_ACT);
        vblank_d   = (v_d >= VA_BEG) && (v_d < VA_END);
        blank_d    = hblank_d & vblank_d;
        hsync_d    = ~((h_d >= HS_BEG) && (h_d < HS_END));
        vsync_d    = ~((v_d >= VS_BEG) && (v_d < VS_END));
        csync_d    = vsync_d ? hsync_d : ~hsync_d;
        vclk_d     = (h_d < H_HALF);
        dma_d      = ~((v_d >= VA_END) && (v_d < DMA_END));
        hflipcnt_d = h_d ^ {HW{hflip_d}};
        vflipcnt_d = v_d ^ {VW{vflip_d}};
    end

    // State and output registers; reset values match the decode of raster (0,0).
    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            div_q      <= {DW{1'b0}};
            pxpos_q    <= 1'b1;
            pxneg_q    <= 1'b1;
            h_q        <= {HW{1'b0}};
            v_q        <= {VW{1'b0}};
            vmode_q    <= 1'b0;
            parity_q   <= 1'b0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            hblank_q   <= 1'b1;
            vblank_q   <= 1'b0;
            blank_q    <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            csync_q    <= 1'b1;
            vclk_q     <= 1'b1;
            dma_q      <= 1'b1;
            hflipcnt_q <= {HW{1'b0}};
            vflipcnt_q <= {VW{1'b0}};
        end else begin
            div_q      <= div_d;
            pxpos_q    <= pxpos_d;
            pxneg_q    <= pxneg_d;
            h_q        <= h_d;
            v_q        <= v_d;
            vmode_q    <= vmode_d;
            parity_q   <= parity_d;
            hflip_q    <= hflip_d;
            vflip_q    <= vflip_d;
            hblank_q   <= hblank_d;
            vblank_q   <= vblank_d;
            blank_q    <= blank_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            csync_q    <= csync_d;
            vclk_q     <= vclk_d;
            dma_q      <= dma_d;
            hflipcnt_q <= hflipcnt_d;
            vflipcnt_q <= vflipcnt_d;
        end
    end

    assign o_PXPOSCEN_n  = pxpos_q;
    assign o_PXNEGCEN_n  = pxneg_q;
    assign o_HCNTR       = h_q;
    assign o_VCNTR       = v_q;
    assign o_HFLIPCNTR   = hflipcnt_q;
    assign o_VFLIPCNTR   = vflipcnt_q;
    assign o_HBLANK_n    = hblank_q;
    assign o_VBLANK_n    = vblank_q;
    assign o_BLANK_n     = blank_q;
    assign o_HSYNC_n     = hsync_q;
    assign o_VSYNC_n     = vsync_q;
    assign o_CSYNC_n     = csync_q;
    assign o_VCLK        = vclk_q;
    assign o_FRAMEPARITY = parity_q;
    assign o_DMA_n       = dma_q;

endmodule

// File: doc/video_timing_gen_param.md
Name: video_timing_gen_param

Overview:
- Parametrised successor to the fixed-raster video timing generator.
- Derives pixel clock enables from i_MCLK, runs the H/V raster counters and decodes blanking, sync, flip counters, line clock, frame parity and a vertical DMA window.
- Adds two behaviours to the fixed generator:
  - runtime selection between two vertical totals;
  - frame-synchronous latching of the flip controls.
- Sits at the top of the video pipeline and feeds the tilemap, object and CPU-arbitration blocks.

Parameters:
CEN_DIV, 8, MCLK cycles per pixel; even, >=2
HW, 9, horizontal counter width
VW, 9, vertical counter width
H_TOTAL, 384, pixels per line (counter 0..H_TOTAL-1)
H_ACT_END, 256, first horizontally blanked pixel (active 0..H_ACT_END-1)
H_SYNC_START, 288, first pixel of HSYNC
H_SYNC_END, 320, first pixel after HSYNC
V_TOTAL_0, 264, lines per frame, mode 0
V_TOTAL_1, 262, lines per frame, mode 1
V_ACT_START, 16, first active line
V_ACT_END, 240, first vertically blanked line after active
V_SYNC_START, 248, first VSYNC line
V_SYNC_END, 256, first line after VSYNC
DMA_LINES, 4, length of the DMA window in lines

Ports:
i_MCLK  in  1  master clock
i_MRST_n  in  1  asynchronous active-low reset
i_HFLIP  in  1  horizontal flip request
i_VFLIP  in  1  vertical flip request
i_VMODE  in  1  vertical total select (0: V_TOTAL_0, 1: V_TOTAL_1)
o_PXPOSCEN_n  out  1  pixel positive clock enable, active low
o_PXNEGCEN_n  out  1  pixel negative clock enable, active low
o_HCNTR  out  HW  absolute horizontal count
o_VCNTR  out  VW  absolute vertical count
o_HFLIPCNTR  out  HW  flipped horizontal count
o_VFLIPCNTR  out  VW  flipped vertical count
o_HBLANK_n  out  1  horizontal active
o_VBLANK_n  out  1  vertical active
o_BLANK_n  out  1  HBLANK_n AND VBLANK_n
o_HSYNC_n  out  1  horizontal sync
o_VSYNC_n  out  1  vertical sync
o_CSYNC_n  out  1  composite sync
o_VCLK  out  1  line clock, high for pixels 0..H_TOTAL/2-1
o_FRAMEPARITY  out  1  toggles every frame
o_DMA_n  out  1  DMA window, active low

Behaviour:
- Clocking and reset: single clock domain on posedge i_MCLK. i_MRST_n clears all state asynchronously; release is synchronous.
- Divider: div counts 0..CEN_DIV-1 and wraps.
  - o_PXPOSCEN_n is low exactly while div==CEN_DIV-1.
  - o_PXNEGCEN_n is low exactly while div==CEN_DIV/2-1.
  - Both are registered: the low level appears in the cycle after div reaches the value.
- Raster advance: h advances on the MCLK edge that ends a PXPOSCEN_n-low cycle.
  - h wraps H_TOTAL-1 -> 0 and increments v.
  - v wraps vtot-1 -> 0, where vtot is the latched mode.
- Line-0 wrap event (the edge where v returns to 0):
  - latches i_VMODE into vmode_q; a mid-frame change of i_VMODE has no effect until the next wrap;
  - toggles o_FRAMEPARITY.
- Flip latch: i_HFLIP/i_VFLIP are latched into hflip_q/vflip_q on the edge where v enters V_ACT_END, so flip only changes inside vblank.
- Flip counters: o_HFLIPCNTR = h XOR {HW{hflip_q}}; o_VFLIPCNTR = v XOR {VW{vflip_q}}.
- Registered decodes, all updated on the same edge as the counters they decode:
  - HBLANK_n = (h < H_ACT_END)
  - VBLANK_n = (V_ACT_START <= v < V_ACT_END)
  - HSYNC_n = !(H_SYNC_START <= h < H_SYNC_END)
  - VSYNC_n = !(V_SYNC_START <= v < V_SYNC_END)
  - CSYNC_n = VSYNC_n ? HSYNC_n : !HSYNC_n
  - DMA_n = !(V_ACT_END <= v < V_ACT_END+DMA_LINES)
- Reset values:
  - div=0, h=0, v=0;
  - PXPOSCEN_n=1, PXNEGCEN_n=1;
  - HBLANK_n=1, VBLANK_n=0, BLANK_n=0;
  - HSYNC_n=1, VSYNC_n=1, CSYNC_n=1;
  - VCLK=1, FRAMEPARITY=0, DMA_n=1;
  - hflip_q=0, vflip_q=0, vmode_q=0;
  - HFLIPCNTR=0, VFLIPCNTR=0.
- Reset mid-frame: all outputs return to their reset values immediately; the raster restarts at (0,0).
- Parameter legality is checked by elaboration assertions:
  - H_SYNC_END <= H_TOTAL;
  - V_SYNC_END <= min(V_TOTAL_0, V_TOTAL_1);
  - V_ACT_END + DMA_LINES <= min(V_TOTAL_0, V_TOTAL_1).

Test Plan:
- Divider: release reset, count 24 MCLK -> PXPOSCEN_n low at cycles 8, 16, 24 only; PXNEGCEN_n low at cycles 4, 12, 20.
- Line timing, defaults: one line spans 384*8 = 3072 MCLK. HBLANK_n falls at h=256. HSYNC_n is low for h=288..319. VCLK high for h=0..191.
- Frame and mode: VMODE=0 -> v wraps after 263 and FRAMEPARITY toggles. Set VMODE=1 at v=100 -> the current frame still ends at 263, the next frame wraps after 261.
- Vertical decode: VBLANK_n high for v=16..239. VSYNC_n low for v=248..255. DMA_n low for v=240..243. CSYNC_n equals the inverted HSYNC_n during v=248..255.
- Flip: assert i_HFLIP and i_VFLIP at v=50 -> flip counters unchanged until v=240, then o_HFLIPCNTR=h^9'h1FF and o_VFLIPCNTR=v^9'h1FF.
- Async reset at v=120, h=77 -> all outputs at reset values within the same cycle; after release, h counts from 0 and the first PXPOSCEN_n comes 8 MCLK later.
